// File: rtl/pc_sequencer.sv
// Program-counter and fetch sequencer for the 16-bit processor.
// Fetches one instruction word, waits for control to resolve it, then chooses the next PC.
module pc_sequencer #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter logic [15:0] PC_STEP      = 16'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic [15:0] ir,
  output logic        ir_valid,
  input  logic        ctrl_done,
  input  logic        br_take,
  input  logic [15:0] br_offset,
  input  logic        jump,
  input  logic [15:0] jump_target,
  input  logic        link_en,
  output logic [15:0] link,
  output logic [15:0] pc,
  output logic        misalign
);

  typedef enum logic [0:0] {
    FETCH     = 1'b0,
    WAIT_CTRL = 1'b1
  } state_t;

  localparam logic [15:0] PC_RESET = {RESET_VECTOR[15:1], 1'b0};

  state_t      state_reg, state_next;
  logic [15:0] pc_reg, pc_next;
  logic [15:0] ir_reg, ir_next;
  logic [15:0] link_reg, link_next;
  logic        misalign_reg, misalign_next;
  logic [15:0] target;
  logic [15:0] seq_pc;

  // Sequential address doubles as the return address saved into LINK.
  assign seq_pc = pc_reg + PC_STEP;

  always_comb begin
    target = seq_pc;
    if (jump) begin
      target = jump_target;
    end else if (br_take) begin
      target = pc_reg + br_offset;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= FETCH;
      pc_reg       <= PC_RESET;
      ir_reg       <= 16'h0000;
      link_reg     <= 16'h0000;
      misalign_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      ir_reg       <= ir_next;
      link_reg     <= link_next;
      misalign_reg <= misalign_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    ir_next       = ir_reg;
    link_next     = link_reg;
    misalign_next = 1'b0;
    case (state_reg)
      FETCH: begin
        if (imem_ack) begin
          ir_next    = imem_data;
          state_next = WAIT_CTRL;
        end
      end
      WAIT_CTRL: begin
        if (ctrl_done) begin
          // Odd targets are truncated to the word boundary and flagged for one cycle.
          pc_next       = {target[15:1], 1'b0};
          misalign_next = target[0];
          if (link_en) begin
            link_next = seq_pc;
          end
          state_next = FETCH;
        end
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  assign imem_req  = (state_reg == FETCH);
  assign ir_valid  = (state_reg == WAIT_CTRL);
  assign imem_addr = pc_reg;
  assign pc        = pc_reg;
  assign ir        = ir_reg;
  assign link      = link_reg;
  assign misalign  = misalign_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed plan steps followed by randomized traffic,
// compared every cycle against a transaction-level reference model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_data = 16'h0000;
  logic [15:0] ir;
  logic        ir_valid;
  logic        ctrl_done = 1'b0;
  logic        br_take = 1'b0;
  logic [15:0] br_offset = 16'h0000;
  logic        jump = 1'b0;
  logic [15:0] jump_target = 16'h0000;
  logic        link_en = 1'b0;
  logic [15:0] link;
  logic [15:0] pc;
  logic        misalign;

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit        m_wait;
  int        m_pc;
  int        m_ir;
  int        m_link;
  bit        m_mis;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .ir(ir), .ir_valid(ir_valid),
    .ctrl_done(ctrl_done), .br_take(br_take), .br_offset(br_offset), .jump(jump),
    .jump_target(jump_target), .link_en(link_en), .link(link), .pc(pc), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_wait = 1'b0;
    m_pc   = 0;
    m_ir   = 0;
    m_link = 0;
    m_mis  = 1'b0;
  endfunction

  // One clock of architectural behaviour, evaluated from the inputs present at the edge.
  function automatic void model_step();
    int t;
    m_mis = 1'b0;
    if (!m_wait) begin
      if (imem_ack) begin
        m_ir   = int'(imem_data);
        m_wait = 1'b1;
      end
    end else if (ctrl_done) begin
      if (jump)         t = int'(jump_target);
      else if (br_take) t = (m_pc + int'(br_offset)) % 65536;
      else              t = (m_pc + 2) % 65536;
      if (link_en) m_link = (m_pc + 2) % 65536;
      m_mis  = (t % 2) == 1;
      m_pc   = t - (t % 2);
      m_wait = 1'b0;
    end
  endfunction

  task automatic check_all();
    chk("imem_req",  {15'd0, imem_req},  {15'd0, !m_wait});
    chk("imem_addr", imem_addr,          16'(m_pc));
    chk("pc",        pc,                 16'(m_pc));
    chk("ir",        ir,                 16'(m_ir));
    chk("ir_valid",  {15'd0, ir_valid},  {15'd0, m_wait});
    chk("link",      link,               16'(m_link));
    chk("misalign",  {15'd0, misalign},  {15'd0, m_mis});
  endtask

  task automatic tick(input bit ack, input logic [15:0] data, input bit done, input bit br,
                      input logic [15:0] off, input bit jmp, input logic [15:0] tgt, input bit len);
    imem_ack = ack; imem_data = data; ctrl_done = done; br_take = br;
    br_offset = off; jump = jmp; jump_target = tgt; link_en = len;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
    check_all();
    $display("t=%0t addr=%h ir=%h ir_valid=%0b pc=%h link=%h misalign=%0b",
             $time, imem_addr, ir, ir_valid, pc, link, misalign);
  endtask

  // Fetch with immediate ACK, then resolve on the next cycle.
  task automatic instr(input logic [15:0] data, input bit br, input logic [15:0] off,
                       input bit jmp, input logic [15:0] tgt, input bit len);
    tick(1'b1, data, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    tick(1'b0, 16'h0, 1'b1, br, off, jmp, tgt, len);
  endtask

  initial begin
    model_reset();
    // Reset held for 3 cycles
    repeat (3) tick(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    rst_n = 1'b1;
    chk("reset_req", {15'd0, imem_req}, 16'd1);

    // Sequential fetches
    instr(16'hA001, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    chk("seq_addr1", imem_addr, 16'h0002);
    instr(16'hA002, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    instr(16'hA003, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    chk("seq_addr3", imem_addr, 16'h0006);
    chk("seq_ir3", ir, 16'hA003);

    // Branches with shifted offsets from 0x0010
    instr(16'h1111, 1'b0, 16'h0, 1'b1, 16'h0010, 1'b0);
    instr(16'h2222, 1'b1, 16'h0024, 1'b0, 16'h0, 1'b0);
    chk("br_fwd", pc, 16'h0034);
    instr(16'h3333, 1'b1, 16'hFFF6, 1'b0, 16'h0, 1'b0);
    chk("br_back", pc, 16'h002A);

    // Wrap and jump priority
    instr(16'h4444, 1'b0, 16'h0, 1'b1, 16'hFFFE, 1'b0);
    instr(16'h5555, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    chk("wrap", pc, 16'h0000);
    instr(16'h6666, 1'b1, 16'h0100, 1'b1, 16'h0400, 1'b0);
    chk("jump_prio", pc, 16'h0400);

    // Link with misaligned jump target
    instr(16'h7777, 1'b0, 16'h0, 1'b1, 16'h0100, 1'b0);
    instr(16'h8888, 1'b0, 16'h0, 1'b1, 16'h0201, 1'b1);
    chk("link_val", link, 16'h0102);
    chk("mis_pc", pc, 16'h0200);
    chk("mis_pulse", {15'd0, misalign}, 16'd1);
    tick(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    chk("mis_drop", {15'd0, misalign}, 16'd0);

    // Fetch stall with a spurious CTRL_DONE
    for (int i = 0; i < 5; i++)
      tick(1'b0, 16'hDEAD, (i == 2), 1'b0, 16'h0, 1'b1, 16'h0800, 1'b1);
    chk("stall_addr", imem_addr, 16'h0200);

    // Reset in WAIT_CTRL at PC=0x0040
    instr(16'h9999, 1'b0, 16'h0, 1'b1, 16'h0040, 1'b0);
    tick(1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    chk("wait_state", {15'd0, ir_valid}, 16'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("async_pc", pc, 16'h0000);
    tick(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_req", {15'd0, imem_req}, 16'd1);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      tick(($urandom_range(0, 1) == 1), 16'($urandom), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 1) == 1), 16'($urandom), ($urandom_range(0, 3) == 0),
           16'($urandom), ($urandom_range(0, 1) == 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter and fetch sequencer for the 16-bit processor.
- Sits directly downstream of the 1-bit left shifter. It consumes the shifted, sign-extended branch offset (word offset converted to byte offset) and adds it to the PC.
- Owns the PC register, the instruction-fetch handshake, the instruction register and the link (return-address) register.
- Hands each fetched instruction to control and waits for control's resolution before choosing the next PC.

Parameters:
- RESET_VECTOR, 16'h0000, PC value loaded on reset.
- PC_STEP, 16'd2, sequential increment in bytes; instructions are 16-bit words.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- IMEM_REQ  output  1  fetch request to instruction memory.
- IMEM_ADDR  output  16  fetch address; always equals PC.
- IMEM_ACK  input  1  memory accepted the request; IMEM_DATA is valid this cycle.
- IMEM_DATA  input  16  fetched instruction word.
- IR  output  16  latched instruction.
- IR_VALID  output  1  IR holds an instruction awaiting resolution.
- CTRL_DONE  input  1  single-cycle pulse: control has resolved the current instruction.
- BR_TAKE  input  1  conditional branch taken; sampled only with CTRL_DONE.
- BR_OFFSET  input  16  byte offset, already shifted left by 1 upstream (two's complement).
- JUMP  input  1  absolute jump; sampled only with CTRL_DONE.
- JUMP_TARGET  input  16  absolute jump address.
- LINK_EN  input  1  save the return address; sampled only with CTRL_DONE.
- LINK  output  16  last saved return address.
- PC  output  16  current program counter.
- MISALIGN  output  1  one-cycle pulse: the computed target had bit0 set.

Behaviour:
- Reset (RST_N low, asynchronous, takes effect immediately) sets:
  - PC = RESET_VECTOR, with bit0 forced to 0.
  - IR = 0, LINK = 0, MISALIGN = 0, IR_VALID = 0.
  - FSM = FETCH, so IMEM_REQ = 1 from the first cycle after release.
- Reset asserted mid-fetch or mid-wait aborts the operation. No partial PC or IR update survives.
- FSM states:
  - FETCH: IMEM_REQ=1, IMEM_ADDR=PC, IR_VALID=0.
    - On IMEM_ACK: IR <= IMEM_DATA, go to WAIT_CTRL.
    - With no ACK the block stays in FETCH with PC and request held stable (no timeout).
  - WAIT_CTRL: IMEM_REQ=0, IR_VALID=1.
    - On CTRL_DONE: load PC with next_pc, update LINK if required, go to FETCH.
    - CTRL_DONE is ignored while in FETCH.
- next_pc priority, all arithmetic 16-bit modulo 2^16 (wraps silently, no carry out):
  - JUMP=1: JUMP_TARGET.
  - else BR_TAKE=1: PC + BR_OFFSET.
  - else: PC + PC_STEP.
  - When JUMP and BR_TAKE are both set, JUMP wins.
- Alignment: if next_pc[0]=1, PC loads next_pc with bit0 cleared and MISALIGN pulses high for exactly the cycle after the update.
- LINK: when LINK_EN=1 with CTRL_DONE, LINK <= PC + PC_STEP, computed from the old PC. This holds regardless of the JUMP or BR_TAKE values.
- Latency:
  - Minimum per instruction is 2 cycles: ACK in cycle n, CTRL_DONE in cycle n+1.
  - The new PC is visible on the cycle after CTRL_DONE.
  - IMEM_ADDR changes only on the clock edge that leaves WAIT_CTRL.
- IR holds its value until the next ACK. IR_VALID drops on the same edge that CTRL_DONE is accepted.

Test Plan:
- Reset/sequential: hold RST_N low 3 cycles, release; ACK immediately and CTRL_DONE 1 cycle later, repeated 3 times -> IMEM_ADDR sequence 0x0000, 0x0002, 0x0004, 0x0006; IR captures each IMEM_DATA.
- Branch using shifted offsets, starting at PC=0x0010:
  - BR_TAKE with BR_OFFSET=0x0024 (shifter output of 0x0012) -> PC=0x0034.
  - BR_TAKE with BR_OFFSET=0xFFF6 (-10) from 0x0034 -> PC=0x002A.
- Wrap and priority:
  - PC=0xFFFE sequential -> PC=0x0000.
  - BR_TAKE and JUMP together with JUMP_TARGET=0x0400 -> PC=0x0400.
- Link and misalign:
  - LINK_EN+JUMP at PC=0x0100, JUMP_TARGET=0x0201 -> LINK=0x0102, PC=0x0200, MISALIGN high exactly 1 cycle.
- Fetch stall: withhold IMEM_ACK for 5 cycles -> IMEM_REQ stays high, IMEM_ADDR stable, IR_VALID=0; CTRL_DONE pulsed during the stall has no effect.
- Reset mid-wait: assert RST_N low while in WAIT_CTRL at PC=0x0040 -> PC=0x0000, IR_VALID=0, IMEM_REQ=1 immediately after release.
